seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Four-digit time-multiplexed display scanner sitting directly upstream of the `seven_segment` decoder. Holds a 16-bit hex value and presents one 4-bit nibble per refresh slot to the decoder, together with an active-low digit-select for the common-anode display. New values are double-buffered and only take effect at a frame boundary, so a digit never shows a mix of old and new data. Optional leading-zero blanking is available.

## Interface
- `DIV`, 50000: clock cycles per digit slot; legal range ≥ 1.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `load`  input  1  single-cycle strobe; captures `value_in`.
- `value_in`  input  16  four hex nibbles; digit d = `value_in[4d+3:4d]`; digit 0 is rightmost.
- `nibble`  output  4  current digit's nibble; connects to `seven_segment.in`.
- `an`  output  4  active-low digit select, one-hot-low; `4'b1111` means all off.
- `blank`  output  1  high when the current slot is blanked.
- `frame_start`  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Registers:
  - prescaler `cnt` (width `$clog2(DIV)`, min 1);
  - digit index `idx` [1:0];
  - `active` [15:0];
  - `pending` [15:0];
  - `pend_vld`.
- Tick occurs when `cnt == DIV-1`. On tick: `cnt` goes to 0 and `idx` goes to `idx+1` mod 4. Otherwise `cnt` goes to `cnt+1`.
- Scan state machine: states DIG0 to DIG3, matching `idx`. Transitions occur only on tick: DIG0→DIG1→DIG2→DIG3→DIG0.
- Frame boundary is a tick while `idx == 3`. In that cycle `frame_start` = 1, and the update below is applied.
- Shadow update, priority in this order:
  - `load` and boundary in the same cycle: `active` ← `value_in`, `pend_vld` ← 0. This bypass means the value is not lost.
  - `load` only: `pending` ← `value_in`, `pend_vld` ← 1. A later `load` before the boundary overwrites `pending`; last write wins.
  - boundary only with `pend_vld` = 1: `active` ← `pending`, `pend_vld` ← 0.
  - boundary with `pend_vld` = 0: `active` unchanged.
- Outputs are combinational from registers only (no input-to-output path):
  - `nibble` = `active[4*idx +: 4]`;
  - `an` = `~(4'b0001 << idx)`, or `4'b1111` when `blank`;
  - `blank` per Configuration (0 when the feature is off);
  - `frame_start` = tick & (`idx == 3`).
- `nibble` is still driven with the digit's data while blanked; only `an` is suppressed.

## Timing
- Reset values, applied at the first `clk` edge with `rst` = 1:
  - `cnt` = 0, `idx` = 0, `active` = 0, `pending` = 0, `pend_vld` = 0;
  - therefore `nibble` = 0, `an` = `4'b1110`, `blank` = 0, `frame_start` = 0.
- Reset mid-operation discards `pending` and restarts at DIG0 with slot count 0. `rst` overrides `load` in the same cycle.
- Each digit is driven for exactly `DIV` cycles; a frame is `4*DIV` cycles.
- After reset, the first `frame_start` occurs `4*DIV-1` cycles after the reset edge.
- `DIV` = 1: a tick every cycle, `idx` advances every cycle, and `frame_start` is high every 4th cycle.
- Load-to-display latency: the value appears on `nibble` in the cycle after the next boundary edge. Worst case is `4*DIV` cycles; best case is 1 cycle when `load` coincides with the boundary.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digit d ∈ {1,2,3} is blanked during its slot if `active` nibbles d..3 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - `blank` = 1 and `an` = `4'b1111` for blanked slots.
  - Slot timing is unchanged; blanked slots are not skipped.
- Undefined: `blank` is tied 0, and every slot drives its `an` bit low.

## Test plan
All scenarios use `DIV` = 4.
- Reset, then idle: `an` sequence `1110`, `1101`, `1011`, `0111`, each held 4 cycles, then repeating. `nibble` = 0 throughout. `frame_start` is high only at cycle 15, 31, ….
- `load`=1 with `value_in`=`16'h1A2F` at cycle 5 (DIG1): `nibble` stays 0 until the boundary. Starting the cycle after the boundary at cycle 15, `nibble` reads F, 2, A, 1 per slot.
- Two loads, `16'h1111` then `16'h2222`, within one frame: only `2222` is ever displayed; `1111` never appears.
- `load` of `16'hBEEF` in exactly the `frame_start` cycle: the next cycle shows `an` = `1110` and `nibble` = F. `pend_vld` = 0.
- `rst` asserted at cycle 9 with a pending value: the next cycle shows `an` = `1110` and `nibble` = 0. The pending value is never displayed.
- With `SEG_SCAN_LZB_EN`, load `16'h0070`:
  - digit 0 shows 0 with `an` = `1110`;
  - digit 1 shows 7 with `an` = `1101`;
  - digits 2 and 3 have `blank` = 1 and `an` = `1111`.

  Load `16'h0000`: only digit 0 is lit. Without the macro: all four digits are lit and `blank` = 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Four-digit time-multiplexed scanner for a common-anode seven-segment
// display. It holds a 16-bit hex value and presents one nibble per refresh
// slot to the downstream seven_segment decoder. It also drives an
// active-low, one-hot digit select. A newly loaded value waits in a shadow
// register until the scan wraps from digit 3 to digit 0. This keeps a
// frame from mixing old and new data.
//
// Optional feature macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
//
// Parameters:
//   DIV          clock cycles per digit slot (>= 1)
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   load         single-cycle strobe capturing value_in
//   value_in     four hex nibbles, digit 0 in bits [3:0] (rightmost)
//   nibble       nibble of the digit in the current slot
//   an           active-low digit select, 4'b1111 = all off
//   blank        high while the current slot is blanked
//   frame_start  one-cycle pulse on the digit 3 -> digit 0 wrap
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame_start
);

  // The prescaler needs at least one bit even when DIV is 1.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_vld;
  logic          tick;
  logic          boundary;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (state == DIG3);
  assign idx      = state;

  // Slot prescaler: counts 0..DIV-1 and wraps on each tick.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan state register. The state value doubles as the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIG0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG3;
        DIG3:    state_nxt = DIG0;
        default: state_nxt = DIG0;
      endcase
    end
  end

  // Double buffer. When a load lands on the frame boundary, the load
  // bypasses the shadow register and goes straight to active. The stale
  // pending value is then dropped, so the load is neither lost nor
  // overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= '0;
      pending  <= '0;
      pend_vld <= 1'b0;
    end else if (load && boundary) begin
      active   <= value_in;
      pend_vld <= 1'b0;
    end else if (load) begin
      pending  <= value_in;
      pend_vld <= 1'b1;
    end else if (boundary && pend_vld) begin
      active   <= pending;
      pend_vld <= 1'b0;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // A digit is blanked when it and every digit to its left are zero.
  // Digit 0 always stays lit so that a value of zero still shows "0".
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (active[15:4]  == 12'h000);
      2'd2:    blank = (active[15:8]  == 8'h00);
      2'd3:    blank = (active[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // The outputs depend only on registers. The nibble keeps its data even
  // while the slot is blanked; only the anode is suppressed.
  always_comb begin
    nibble      = active[{idx, 2'b00} +: 4];
    an          = blank ? 4'b1111 : ~(4'b0001 << idx);
    frame_start = boundary;
  end

endmodule
